operand_fetch_stage: RTL and testbench

- Next-generation decode/operand-read stage. Holds the register bank.
- Resolves operand hazards against NUM_BYPASS parametrised forwarding sources. Each source carries a ready flag, so hazards against results not yet produced cause a real stall.
- Tracks in-flight long-latency writes (loads, multi-cycle ops) in a per-register scoreboard.
- Registers the decoded packet into a valid/ready output stage feeding the ALU, with flush support.

---
 rtl/operand_fetch_stage.sv | 157 +++++++++++++++
 tb/tb_operand_fetch_stage.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch_stage.sv
// Decode/operand-read stage: register bank, bypass/scoreboard hazard resolution,
// and a registered valid/ready packet stage toward the ALU with flush support.
module operand_fetch_stage #(
  parameter int REG_ADDRESS_SIZE = 5,
  parameter int REG_SIZE         = 32,
  parameter int ADDRESS_SIZE     = 32,
  parameter int NUM_BYPASS       = 3,
  parameter int STATIC_SIZE      = REG_ADDRESS_SIZE + 3 + ADDRESS_SIZE
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [REG_ADDRESS_SIZE-1:0]              addr_r1,
  input  logic [REG_ADDRESS_SIZE-1:0]              addr_r2,
  input  logic [REG_ADDRESS_SIZE-1:0]              addr_rd,
  input  logic                                     rd_we,
  input  logic                                     long_lat,
  input  logic [REG_SIZE-1:0]                      immediate,
  input  logic                                     imm_en,
  input  logic [STATIC_SIZE-1:0]                   static_in,
  input  logic [REG_ADDRESS_SIZE-1:0]              wb_addr,
  input  logic [REG_SIZE-1:0]                      wb_data,
  input  logic                                     wb_we,
  input  logic                                     wb_long,
  input  logic [NUM_BYPASS*(REG_ADDRESS_SIZE+2)-1:0] byp_d,
  input  logic [NUM_BYPASS*REG_SIZE-1:0]           byp_data,
  input  logic                                     flush,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [REG_SIZE-1:0]                      out_operand1,
  output logic [REG_SIZE-1:0]                      out_operand2,
  output logic [REG_ADDRESS_SIZE-1:0]              out_addr_rd,
  output logic                                     out_rd_we,
  output logic                                     out_long_lat,
  output logic [STATIC_SIZE-1:0]                   out_static,
  output logic                                     stall
);

  localparam int DEPTH = 2 ** REG_ADDRESS_SIZE;
  localparam int BW    = REG_ADDRESS_SIZE + 2;

  logic [REG_SIZE-1:0]         r_bank [DEPTH];
  logic [DEPTH-1:0]            r_pending;
  logic                        r_out_valid;
  logic [REG_SIZE-1:0]         r_out_operand1;
  logic [REG_SIZE-1:0]         r_out_operand2;
  logic [REG_ADDRESS_SIZE-1:0] r_out_addr_rd;
  logic                        r_out_rd_we;
  logic                        r_out_long_lat;
  logic [STATIC_SIZE-1:0]      r_out_static;

  logic [REG_SIZE-1:0]         w_bank1;
  logic [REG_SIZE-1:0]         w_bank2;
  logic                        w_pend1;
  logic                        w_pend2;
  logic [REG_SIZE:0]           w_res1;
  logic [REG_SIZE:0]           w_res2;
  logic [REG_SIZE-1:0]         w_op2;
  logic                        w_hazard;
  logic                        w_in_ready;
  logic                        w_accept;
  logic [DEPTH-1:0]            w_pend_next;

  // Returns {hazard, data}. Scanning from the oldest source down lets source 0 win.
  function automatic logic [REG_SIZE:0] f_resolve(
    input logic [REG_ADDRESS_SIZE-1:0]   a,
    input logic [NUM_BYPASS*BW-1:0]      d,
    input logic [NUM_BYPASS*REG_SIZE-1:0] dat,
    input logic [REG_SIZE-1:0]           bank_val,
    input logic                          pend_hz
  );
    logic [REG_SIZE:0] res;
    res = {pend_hz, bank_val};
    for (int s = NUM_BYPASS - 1; s >= 0; s--) begin
      if (d[s*BW] && (d[s*BW+2 +: REG_ADDRESS_SIZE] == a))
        res = {~d[s*BW+1], dat[s*REG_SIZE +: REG_SIZE]};
    end
    return res;
  endfunction

  assign w_bank1 = (wb_we && (wb_addr == addr_r1)) ? wb_data : r_bank[addr_r1];
  assign w_bank2 = (wb_we && (wb_addr == addr_r2)) ? wb_data : r_bank[addr_r2];
  // A long-latency result landing this cycle satisfies its reader via write-through.
  assign w_pend1 = r_pending[addr_r1] & ~(wb_we & wb_long & (wb_addr == addr_r1));
  assign w_pend2 = r_pending[addr_r2] & ~(wb_we & wb_long & (wb_addr == addr_r2));

  assign w_res1 = f_resolve(addr_r1, byp_d, byp_data, w_bank1, w_pend1);
  assign w_res2 = f_resolve(addr_r2, byp_d, byp_data, w_bank2, w_pend2);
  assign w_op2  = imm_en ? immediate : w_res2[REG_SIZE-1:0];

  assign w_hazard = w_res1[REG_SIZE] | (~imm_en & w_res2[REG_SIZE]) |
                    (rd_we & long_lat & r_pending[addr_rd]);

  // Handshake: a transfer happens on a side only in a cycle where its valid and
  // ready are both high; out_* are stable while out_valid & ~out_ready.
  assign w_in_ready = ~reset & ~flush & ~w_hazard & (~r_out_valid | out_ready);
  assign w_accept   = in_valid & w_in_ready;

  assign in_ready     = w_in_ready;
  assign stall        = in_valid & ~w_in_ready;
  assign out_valid    = r_out_valid;
  assign out_operand1 = r_out_operand1;
  assign out_operand2 = r_out_operand2;
  assign out_addr_rd  = r_out_addr_rd;
  assign out_rd_we    = r_out_rd_we;
  assign out_long_lat = r_out_long_lat;
  assign out_static   = r_out_static;

  always_comb begin
    w_pend_next = r_pending;
    if (flush && r_out_valid && r_out_rd_we && r_out_long_lat)
      w_pend_next[r_out_addr_rd] = 1'b0;
    if (wb_we && wb_long)
      w_pend_next[wb_addr] = 1'b0;
    if (w_accept && rd_we && long_lat)
      w_pend_next[addr_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_bank[i] <= '0;
    end else if (wb_we) begin
      r_bank[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_pending <= '0;
    else       r_pending <= w_pend_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid    <= 1'b0;
      r_out_operand1 <= '0;
      r_out_operand2 <= '0;
      r_out_addr_rd  <= '0;
      r_out_rd_we    <= 1'b0;
      r_out_long_lat <= 1'b0;
      r_out_static   <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid    <= 1'b1;
      r_out_operand1 <= w_res1[REG_SIZE-1:0];
      r_out_operand2 <= w_op2;
      r_out_addr_rd  <= addr_rd;
      r_out_rd_we    <= rd_we;
      r_out_long_lat <= long_lat;
      r_out_static   <= static_in;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Testbench for operand_fetch_stage: directed scenarios plus a randomized run
// compared against a behavioural model of bank, scoreboard and output stage.
module tb_operand_fetch_stage;

  localparam int RA = 5;
  localparam int RS = 32;
  localparam int NB = 3;
  localparam int SS = RA + 3 + 32;

  logic            clk;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [RA-1:0]   addr_r1, addr_r2, addr_rd;
  logic            rd_we, long_lat, imm_en;
  logic [RS-1:0]   immediate;
  logic [SS-1:0]   static_in;
  logic [RA-1:0]   wb_addr;
  logic [RS-1:0]   wb_data;
  logic            wb_we, wb_long;
  logic [NB*(RA+2)-1:0] byp_d;
  logic [NB*RS-1:0]     byp_data;
  logic            flush;
  logic            out_valid, out_ready;
  logic [RS-1:0]   out_operand1, out_operand2;
  logic [RA-1:0]   out_addr_rd;
  logic            out_rd_we, out_long_lat;
  logic [SS-1:0]   out_static;
  logic            stall;

  // bypass sources as plain arrays, packed onto the bus below
  logic            bv [NB];
  logic            br [NB];
  logic [RA-1:0]   ba [NB];
  logic [RS-1:0]   bd [NB];

  int n_tests = 0;
  int n_fail  = 0;

  operand_fetch_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .addr_r1(addr_r1), .addr_r2(addr_r2), .addr_rd(addr_rd),
    .rd_we(rd_we), .long_lat(long_lat), .immediate(immediate), .imm_en(imm_en),
    .static_in(static_in), .wb_addr(wb_addr), .wb_data(wb_data), .wb_we(wb_we),
    .wb_long(wb_long), .byp_d(byp_d), .byp_data(byp_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_operand1(out_operand1),
    .out_operand2(out_operand2), .out_addr_rd(out_addr_rd), .out_rd_we(out_rd_we),
    .out_long_lat(out_long_lat), .out_static(out_static), .stall(stall)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    byp_d    = '0;
    byp_data = '0;
    for (int s = 0; s < NB; s++) begin
      byp_d[s*(RA+2) +: (RA+2)] = {ba[s], br[s], bv[s]};
      byp_data[s*RS +: RS]      = bd[s];
    end
  end

  // ---------------- reference model ----------------
  logic [RS-1:0] m_bank [32];
  logic [31:0]   m_pend;
  logic          m_ov;
  logic [RS-1:0] m_op1, m_op2;
  logic [RA-1:0] m_rd;
  logic          m_we, m_ll;
  logic [SS-1:0] m_static;

  function automatic void m_resolve(input logic [RA-1:0] a, output logic hz, output logic [RS-1:0] v);
    int hit;
    hit = -1;
    for (int s = 0; s < NB; s++)
      if (hit < 0 && bv[s] && ba[s] == a) hit = s;
    if (hit >= 0) begin
      hz = !br[hit];
      v  = bd[hit];
    end else begin
      v  = (wb_we && wb_addr == a) ? wb_data : m_bank[a];
      hz = m_pend[a] && !(wb_we && wb_long && wb_addr == a);
    end
  endfunction

  function automatic void model_eval(output logic hz, output logic [RS-1:0] o1,
                                     output logic [RS-1:0] o2, output logic rdy);
    logic h1, h2;
    logic [RS-1:0] v2;
    m_resolve(addr_r1, h1, o1);
    m_resolve(addr_r2, h2, v2);
    hz  = h1 || (!imm_en && h2) || (rd_we && long_lat && m_pend[addr_rd]);
    o2  = imm_en ? immediate : v2;
    rdy = !reset && !flush && !hz && (!m_ov || out_ready);
  endfunction

  function automatic logic [31:0] pend_next(input logic acc);
    logic [31:0] p;
    p = m_pend;
    if (flush && m_ov && m_we && m_ll) p[m_rd] = 1'b0;
    if (wb_we && wb_long) p[wb_addr] = 1'b0;
    if (acc && rd_we && long_lat) p[addr_rd] = 1'b1;
    return p;
  endfunction

  always @(posedge clk) begin : model_upd
    logic h, r;
    logic [RS-1:0] a, b;
    model_eval(h, a, b, r);
    if (reset) begin
      for (int i = 0; i < 32; i++) m_bank[i] <= '0;
      m_pend <= '0; m_ov <= 1'b0; m_op1 <= '0; m_op2 <= '0;
      m_rd <= '0; m_we <= 1'b0; m_ll <= 1'b0; m_static <= '0;
    end else begin
      if (wb_we) m_bank[wb_addr] <= wb_data;
      m_pend <= pend_next(in_valid && r);
      if (flush) m_ov <= 1'b0;
      else if (in_valid && r) begin
        m_ov <= 1'b1; m_op1 <= a; m_op2 <= b; m_rd <= addr_rd;
        m_we <= rd_we; m_ll <= long_lat; m_static <= static_in;
      end else if (out_ready) m_ov <= 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    in_valid = 0; addr_r1 = 0; addr_r2 = 0; addr_rd = 0; rd_we = 0; long_lat = 0;
    imm_en = 0; immediate = 0; static_in = 0; wb_addr = 0; wb_data = 0; wb_we = 0;
    wb_long = 0; flush = 0; out_ready = 1;
    for (int s = 0; s < NB; s++) begin bv[s] = 0; br[s] = 0; ba[s] = 0; bd[s] = 0; end
  endtask

  task automatic issue(input logic [RA-1:0] a1, input logic [RA-1:0] a2, input logic [RA-1:0] rd,
                       input logic we, input logic ll, input logic ie, input logic [RS-1:0] imm);
    in_valid = 1; addr_r1 = a1; addr_r2 = a2; addr_rd = rd; rd_we = we; long_lat = ll;
    imm_en = ie; immediate = imm; static_in = SS'({$urandom(), $urandom()});
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    set_idle();
    reset = 1;
    in_valid = 1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall: got %b want 1", stall); end
    @(posedge clk); #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_tests++; if (out_operand1 !== '0 || out_operand2 !== '0 || out_static !== '0)
      begin n_fail++; $display("FAIL reset_payload: got %h %h %h want 0", out_operand1, out_operand2, out_static); end
    @(negedge clk);
    reset = 0; in_valid = 0;
  endtask

  task automatic test_writethrough();
    @(negedge clk);
    set_idle();
    wb_we = 1; wb_addr = 3; wb_data = 32'h11;
    @(negedge clk);
    wb_we = 0;
    issue(3, 4, 1, 1, 0, 0, 0);
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL wt_in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL wt_out_valid: got %b want 1", out_valid); end
    n_tests++; if (out_operand1 !== 32'h11) begin n_fail++; $display("FAIL wt_op1: got %h want 11", out_operand1); end
    n_tests++; if (out_operand2 !== 32'h0) begin n_fail++; $display("FAIL wt_op2: got %h want 0", out_operand2); end
    @(negedge clk);
    set_idle();
  endtask

  task automatic test_priority();
    @(negedge clk);
    set_idle();
    bv[0] = 1; br[0] = 1; ba[0] = 5; bd[0] = 32'hA;
    bv[1] = 1; br[1] = 1; ba[1] = 5; bd[1] = 32'hB;
    issue(5, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    n_tests++; if (out_operand1 !== 32'hA) begin n_fail++; $display("FAIL prio_src0: got %h want a", out_operand1); end
    @(negedge clk);
    bv[0] = 0;
    @(posedge clk); #1;
    n_tests++; if (out_operand1 !== 32'hB) begin n_fail++; $display("FAIL prio_src1: got %h want b", out_operand1); end
    @(negedge clk);
    set_idle();
  endtask

  task automatic test_long_lat();
    int k;
    logic [RS-1:0] d;
    @(negedge clk);
    set_idle();
    issue(0, 0, 7, 1, 1, 0, 0);
    @(posedge clk);
    @(negedge clk);
    issue(7, 0, 0, 0, 0, 0, 0);
    k = $urandom_range(2, 5);
    for (int i = 0; i < k; i++) begin
      #1;
      n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL ll_stall[%0d]: got %b want 1", i, stall); end
      @(negedge clk);
    end
    d = $urandom;
    wb_we = 1; wb_long = 1; wb_addr = 7; wb_data = d;
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL ll_release_stall: got %b want 0", stall); end
    @(posedge clk); #1;
    n_tests++; if (out_valid !== 1'b1 || out_operand1 !== d)
      begin n_fail++; $display("FAIL ll_wt_op1: got %b/%h want 1/%h", out_valid, out_operand1, d); end
    @(negedge clk);
    set_idle();
  endtask

  task automatic test_imm();
    logic [RS-1:0] imm;
    @(negedge clk);
    set_idle();
    bv[0] = 1; br[0] = 0; ba[0] = 2; bd[0] = 32'hDEAD;
    imm = $urandom;
    issue(0, 2, 0, 0, 0, 1, imm);
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL imm_no_stall: got %b want 0", stall); end
    @(posedge clk); #1;
    n_tests++; if (out_operand2 !== imm) begin n_fail++; $display("FAIL imm_op2: got %h want %h", out_operand2, imm); end
    @(negedge clk);
    imm_en = 0;
    #1;
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL imm_off_stall: got %b want 1", stall); end
    @(negedge clk);
    set_idle();
  endtask

  task automatic test_hold_flush();
    @(negedge clk);
    set_idle();
    out_ready = 0;
    issue(0, 0, 9, 1, 1, 0, 0);
    @(posedge clk);
    @(negedge clk);
    issue(1, 0, 10, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready[%0d]: got %b want 0", i, in_ready); end
      @(posedge clk); #1;
      n_tests++; if (out_valid !== 1'b1 || out_addr_rd !== 5'd9 || out_long_lat !== 1'b1 || out_rd_we !== 1'b1)
        begin n_fail++; $display("FAIL hold_out[%0d]: got v%b rd%0d ll%b we%b want v1 rd9 ll1 we1", i, out_valid, out_addr_rd, out_long_lat, out_rd_we); end
      @(negedge clk);
    end
    in_valid = 0; flush = 1;
    @(posedge clk); #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
    @(negedge clk);
    flush = 0; out_ready = 1;
    issue(9, 0, 0, 0, 0, 0, 0);
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_pend_clear: got stall %b want 0", stall); end
    @(negedge clk);
    set_idle();
  endtask

  task automatic test_reset_mid_stall();
    @(negedge clk);
    set_idle();
    issue(0, 0, 12, 1, 1, 0, 0);
    @(posedge clk);
    @(negedge clk);
    issue(12, 0, 0, 0, 0, 0, 0);
    #1;
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rms_stall: got %b want 1", stall); end
    @(negedge clk);
    reset = 1;
    @(posedge clk); #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rms_out_valid: got %b want 0", out_valid); end
    @(negedge clk);
    reset = 0;
    issue(12, 3, 0, 0, 0, 0, 0);
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rms_pend_clear: got stall %b want 0", stall); end
    @(posedge clk); #1;
    n_tests++; if (out_operand1 !== '0 || out_operand2 !== '0)
      begin n_fail++; $display("FAIL rms_bank_zero: got %h %h want 0 0", out_operand1, out_operand2); end
    @(negedge clk);
    set_idle();
  endtask

  task automatic test_random();
    logic h, r;
    logic [RS-1:0] a, b;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      reset     = ($urandom_range(0, 49) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      addr_r1   = RA'($urandom_range(0, 7));
      addr_r2   = RA'($urandom_range(0, 7));
      addr_rd   = RA'($urandom_range(0, 7));
      rd_we     = $urandom_range(0, 1) == 1;
      long_lat  = ($urandom_range(0, 3) == 0);
      imm_en    = $urandom_range(0, 1) == 1;
      immediate = $urandom;
      static_in = SS'({$urandom(), $urandom()});
      wb_we     = $urandom_range(0, 1) == 1;
      wb_long   = ($urandom_range(0, 2) == 0);
      wb_addr   = RA'($urandom_range(0, 7));
      wb_data   = $urandom;
      flush     = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int s = 0; s < NB; s++) begin
        bv[s] = ($urandom_range(0, 2) == 0);
        br[s] = $urandom_range(0, 1) == 1;
        ba[s] = RA'($urandom_range(0, 7));
        bd[s] = $urandom;
      end
      #1;
      model_eval(h, a, b, r);
      n_tests++; if (in_ready !== r || stall !== (in_valid && !r))
        begin n_fail++; $display("FAIL rnd_ready[%0d]: got rdy%b stall%b want rdy%b stall%b", c, in_ready, stall, r, in_valid && !r); end
      @(posedge clk); #1;
      n_tests++; if (out_valid !== m_ov || out_operand1 !== m_op1 || out_operand2 !== m_op2 ||
                     out_addr_rd !== m_rd || out_rd_we !== m_we || out_long_lat !== m_ll || out_static !== m_static)
        begin n_fail++; $display("FAIL rnd_out[%0d]: got v%b %h %h rd%0d we%b ll%b want v%b %h %h rd%0d we%b ll%b",
                                 c, out_valid, out_operand1, out_operand2, out_addr_rd, out_rd_we, out_long_lat,
                                 m_ov, m_op1, m_op2, m_rd, m_we, m_ll); end
    end
    @(negedge clk);
    set_idle();
    reset = 0;
  endtask

  initial begin
    reset = 1;
    set_idle();
    test_reset();
    test_writethrough();
    test_priority();
    test_long_lat();
    test_imm();
    test_hold_flush();
    test_reset_mid_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
